// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one W-bit adder between N_REQ requesters.
// A request costs three cycles: grant and latch operands, let the adder settle, then return the result with done.
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] x_in,
    input  logic [N_REQ*W-1:0] y_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic [W-1:0]       add_x,
    output logic [W-1:0]       add_y,
    input  logic [W-1:0]       add_s,
    input  logic               add_cout,
    output logic [W-1:0]       s_out,
    output logic               cout_out,
    output logic [N_REQ-1:0]   done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]                  state;
    logic [IW-1:0]               last;
    logic [IW-1:0]               win;
    logic                        found;
    int                          idx;
    logic [N_REQ-1:0][W-1:0]     xs;
    logic [N_REQ-1:0][W-1:0]     ys;
    logic [W-1:0]                opx;
    logic [W-1:0]                opy;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign xs[i] = x_in[i*W +: W];
        assign ys[i] = y_in[i*W +: W];
    end

    // Scan starts just past the last winner, so the previous winner has lowest priority.
    always_comb begin
        win   = last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            s_out    <= '0;
            cout_out <= 1'b0;
            opx      <= '0;
            opy      <= '0;
            last     <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= N_REQ'(1) << win;
                        opx   <= xs[win];
                        opy   <= ys[win];
                        last  <= win;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    s_out    <= add_s;
                    cout_out <= add_cout;
                    done     <= gnt;
                    state    <= RESP;
                end
                RESP: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign add_x = opx;
    assign add_y = opy;

endmodule
